// File: rtl/console_text_writer.sv
// Byte-stream console writer: cursor tracking, glyph writes, clear and hardware scroll into char RAM.
// One RAM access per granted cycle; charReady only in IDLE, and memReq holds its request until granted.
module console_text_writer #(
    parameter int          COLS   = 80,
    parameter int          ROWS   = 48,
    parameter int          ADDR_W = 14,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              vgaClock,
    input  logic              reset,
    input  logic [7:0]        charData,
    input  logic              charValid,
    output logic              charReady,
    output logic              memReq,
    input  logic              memGrant,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [7:0]        memWData,
    input  logic [7:0]        memRData,
    output logic [6:0]        cursorX,
    output logic [5:0]        cursorY,
    output logic              busy
);

    localparam logic [12:0] L_COLS  = 13'(COLS);
    localparam logic [12:0] L_TOTAL = 13'(COLS * ROWS);
    localparam logic [12:0] L_SCR   = 13'(COLS * (ROWS - 1));
    localparam logic [6:0]  X_MAX   = 7'(COLS - 1);
    localparam logic [5:0]  Y_MAX   = 6'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE, WRITE, CLEAR, SCR_RD, SCR_CAP, SCR_WR, SCR_BLANK
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [6:0]  r_x, w_x;
    logic [5:0]  r_y, w_y;
    logic [12:0] r_cnt, w_cnt;
    logic        r_req, w_req;
    logic        r_we, w_we;
    logic [12:0] r_addr, w_addr;
    logic [7:0]  r_wdata, w_wdata;
    logic        w_grant;
    logic        w_take;
    logic        w_scroll;
    logic [12:0] w_lin;

    assign charReady = (r_state == IDLE) && !reset;
    assign w_take    = charValid && charReady;
    assign w_grant   = r_req && memGrant;
    assign w_lin     = 13'(r_y) * L_COLS + 13'(r_x);

    always_comb begin
        w_state_nxt = r_state;
        w_x         = r_x;
        w_y         = r_y;
        w_cnt       = r_cnt;
        w_req       = r_req;
        w_we        = r_we;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_scroll    = 1'b0;

        case (r_state)
            IDLE: begin
                w_req = 1'b0;
                if (w_take) begin
                    if (charData >= 8'h20 && charData <= 8'h7E) begin
                        w_state_nxt = WRITE;
                        w_req       = 1'b1;
                        w_we        = 1'b1;
                        w_addr      = w_lin;
                        w_wdata     = charData;
                    end else begin
                        case (charData)
                            8'h0D: w_x = '0;
                            8'h0A: begin
                                if (r_y < Y_MAX) w_y = r_y + 6'd1;
                                else             w_scroll = 1'b1;
                            end
                            8'h08: begin
                                if (r_x != 7'd0) begin
                                    w_x = r_x - 7'd1;
                                end else if (r_y != 6'd0) begin
                                    w_x = X_MAX;
                                    w_y = r_y - 6'd1;
                                end
                            end
                            8'h0C: begin
                                w_state_nxt = CLEAR;
                                w_req       = 1'b1;
                                w_we        = 1'b1;
                                w_addr      = '0;
                                w_wdata     = BLANK;
                                w_cnt       = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (w_grant) begin
                    w_state_nxt = IDLE;
                    w_req       = 1'b0;
                    if (r_x == X_MAX) begin
                        w_x = '0;
                        if (r_y < Y_MAX) w_y = r_y + 6'd1;
                        else             w_scroll = 1'b1;
                    end else begin
                        w_x = r_x + 7'd1;
                    end
                end
            end
            CLEAR, SCR_BLANK: begin
                if (w_grant) begin
                    if (r_cnt == L_TOTAL - 13'd1) begin
                        w_state_nxt = IDLE;
                        w_req       = 1'b0;
                        if (r_state == CLEAR) begin
                            w_x = '0;
                            w_y = '0;
                        end
                    end else begin
                        w_cnt  = r_cnt + 13'd1;
                        w_addr = r_cnt + 13'd1;
                    end
                end
            end
            SCR_RD: begin
                if (w_grant) begin
                    w_state_nxt = SCR_CAP;
                    w_req       = 1'b0;
                end
            end
            SCR_CAP: begin
                // Read data is valid exactly this cycle; it becomes the write payload.
                w_state_nxt = SCR_WR;
                w_req       = 1'b1;
                w_we        = 1'b1;
                w_addr      = r_cnt;
                w_wdata     = memRData;
            end
            SCR_WR: begin
                if (w_grant) begin
                    if (r_cnt + 13'd1 == L_SCR) begin
                        w_state_nxt = SCR_BLANK;
                        w_cnt       = L_SCR;
                        w_addr      = L_SCR;
                        w_wdata     = BLANK;
                    end else begin
                        w_state_nxt = SCR_RD;
                        w_cnt       = r_cnt + 13'd1;
                        w_we        = 1'b0;
                        w_addr      = r_cnt + 13'd1 + L_COLS;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_req       = 1'b0;
            end
        endcase

        // Scroll keeps the cursor on the last row and starts by reading row 1.
        if (w_scroll) begin
            w_state_nxt = SCR_RD;
            w_cnt       = '0;
            w_req       = 1'b1;
            w_we        = 1'b0;
            w_addr      = L_COLS;
        end
    end

    always_ff @(posedge vgaClock) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x;
            r_y     <= w_y;
            r_cnt   <= w_cnt;
            r_req   <= w_req;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
        end
    end

    assign memReq   = r_req;
    assign memWe    = r_we;
    assign memAddr  = {{(ADDR_W-13){1'b0}}, r_addr};
    assign memWData = r_wdata;
    assign cursorX  = r_x;
    assign cursorY  = r_y;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_console_text_writer.sv
// Bench for console_text_writer: RAM responder, access-sequence model of the console, directed bytes.
module tb_console_text_writer;

    logic        vgaClock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  charData = 8'h00;
    logic        charValid = 1'b0;
    logic        charReady;
    logic        memReq;
    logic        memGrant = 1'b1;
    logic        memWe;
    logic [13:0] memAddr;
    logic [7:0]  memWData;
    logic [7:0]  memRData = 8'h5A;
    logic [6:0]  cursorX;
    logic [5:0]  cursorY;
    logic        busy;

    console_text_writer dut (
        .vgaClock (vgaClock),
        .reset    (reset),
        .charData (charData),
        .charValid(charValid),
        .charReady(charReady),
        .memReq   (memReq),
        .memGrant (memGrant),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWData (memWData),
        .memRData (memRData),
        .cursorX  (cursorX),
        .cursorY  (cursorY),
        .busy     (busy)
    );

    always #5 vgaClock = ~vgaClock;

    typedef struct packed {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  data;
    } acc_t;

    acc_t        expq[$];
    logic [7:0]  mem [0:16383];
    logic [7:0]  scr [0:3839];
    int          mx = 0;
    int          my = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          grant_toggle = 1'b0;
    bit          rd_pend = 1'b0;
    logic [13:0] rd_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural console model ----------------
    task automatic push_acc(input logic we, input int addr, input logic [7:0] d);
        acc_t e;
        e.we   = we;
        e.addr = 13'(addr);
        e.data = d;
        expq.push_back(e);
    endtask

    task automatic m_row_adv();
        if (my < 47) begin
            my++;
        end else begin
            for (int a = 0; a < 3760; a++) begin
                push_acc(1'b0, a + 80, 8'h00);
                push_acc(1'b1, a, scr[a + 80]);
                scr[a] = scr[a + 80];
            end
            for (int a = 3760; a < 3840; a++) begin
                push_acc(1'b1, a, 8'h20);
                scr[a] = 8'h20;
            end
        end
    endtask

    task automatic m_accept(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_acc(1'b1, my * 80 + mx, c);
            scr[my * 80 + mx] = c;
            mx++;
            if (mx == 80) begin
                mx = 0;
                m_row_adv();
            end
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h0A) begin
            m_row_adv();
        end else if (c == 8'h08) begin
            if (mx > 0) mx--;
            else if (my > 0) begin
                mx = 79;
                my--;
            end
        end else if (c == 8'h0C) begin
            for (int a = 0; a < 3840; a++) begin
                push_acc(1'b1, a, 8'h20);
                scr[a] = 8'h20;
            end
            mx = 0;
            my = 0;
        end
    endtask

    // ---------------- grant and read-data drivers ----------------
    initial begin
        forever begin
            @(posedge vgaClock);
            #1;
            if (grant_toggle) memGrant = !memGrant;
            else              memGrant = 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge vgaClock);
            #1;
            if (rd_pend) begin
                memRData = mem[rd_addr];
                rd_pend  = 1'b0;
            end else begin
                memRData = 8'h5A;
            end
        end
    end

    // ---------------- per-cycle compare + RAM ----------------
    initial begin
        bit          p_held;
        logic [31:0] p_vec;
        acc_t        e;
        p_held = 1'b0;
        p_vec  = '0;
        forever begin
            @(negedge vgaClock);
            chk("req_while_ready", 32'(memReq && charReady), 32'd0);
            if (p_held)
                chk("req_held_stable", 32'({memReq, memWe, memAddr, memWData}), p_vec);
            p_held = 1'b0;
            if (memReq) begin
                chk("busy_with_req", 32'(busy), 32'd1);
                if (memGrant) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_access: we=%0d addr=%0d data=0x%0h, none expected at %0t",
                                 memWe, memAddr, memWData, $time);
                    end else begin
                        e = expq.pop_front();
                        chk("access", 32'({memWe, memAddr, (memWe ? memWData : 8'h00)}),
                            32'({e.we, 1'b0, e.addr, e.data}));
                    end
                    if (memWe) begin
                        mem[memAddr] = memWData;
                    end else begin
                        rd_pend = 1'b1;
                        rd_addr = memAddr;
                    end
                end else begin
                    p_held = 1'b1;
                    p_vec  = 32'({memReq, memWe, memAddr, memWData});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge vgaClock);
        #1;
        charData  = b;
        charValid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge vgaClock);
            if (charReady) ok = 1'b1;
            @(posedge vgaClock);
            #1;
        end
        charValid = 1'b0;
        chk("byte_accepted", 32'(ok), 32'd1);
        if (ok) m_accept(b);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge vgaClock);
            if (charReady) ok = 1'b1;
        end
        chk("idle_within_budget", 32'(ok), 32'd1);
    endtask

    task automatic do_byte(input logic [7:0] b, input int budget);
        send_byte(b);
        wait_idle(budget);
        chk("model_cursor_x", 32'(cursorX), 32'(mx));
        chk("model_cursor_y", 32'(cursorY), 32'(my));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        int  bad;
        bit  found;
        for (int a = 0; a < 16384; a++) mem[a] = 8'h00;
        for (int a = 0; a < 3840; a++) scr[a] = 8'h00;

        // Reset state
        repeat (3) @(posedge vgaClock);
        @(negedge vgaClock);
        chk("rst_charReady", 32'(charReady), 32'd0);
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_memWe", 32'(memWe), 32'd0);
        chk("rst_memAddr", 32'(memAddr), 32'd0);
        chk("rst_memWData", 32'(memWData), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cursor", 32'({cursorX, cursorY}), 32'd0);
        @(posedge vgaClock);
        #1;
        reset = 1'b0;
        @(negedge vgaClock);
        chk("ready_after_release", 32'(charReady), 32'd1);

        // 1: single glyph, grant tied high
        @(posedge vgaClock);
        #1;
        charData  = 8'h41;
        charValid = 1'b1;
        m_accept(8'h41);
        @(posedge vgaClock);
        #1;
        charValid = 1'b0;
        @(negedge vgaClock);
        chk("t1_ready_low", 32'(charReady), 32'd0);
        chk("t1_write", 32'({memReq, memWe, memAddr, memWData}), 32'({1'b1, 1'b1, 14'd0, 8'h41}));
        @(negedge vgaClock);
        chk("t1_ready_back", 32'(charReady), 32'd1);
        chk("t1_cursor_x", 32'(cursorX), 32'd1);
        chk("t1_cursor_y", 32'(cursorY), 32'd0);
        chk("t1_mem0", 32'(mem[0]), 32'h41);

        // 2: a full row with toggling grant, starting at column 0
        do_byte(8'h0D, 10);
        grant_toggle = 1'b1;
        for (int i = 0; i < 80; i++) do_byte(8'h42, 20);
        grant_toggle = 1'b0;
        chk("t2_cursor_x", 32'(cursorX), 32'd0);
        chk("t2_cursor_y", 32'(cursorY), 32'd1);
        chk("t2_mem79", 32'(mem[79]), 32'h42);
        chk("t2_mem80", 32'(mem[80]), 32'h00);
        chk("t2_drained", 32'(expq.size()), 32'd0);

        // 3: CR and BS from (5,3)
        do_byte(8'h0A, 10);
        do_byte(8'h0A, 10);
        for (int i = 0; i < 5; i++) do_byte(8'h44, 10);
        chk("t3_start_x", 32'(cursorX), 32'd5);
        chk("t3_start_y", 32'(cursorY), 32'd3);
        send_byte(8'h0D);
        @(negedge vgaClock);
        chk("t3_cr_noreq", 32'(memReq), 32'd0);
        chk("t3_cr_cursor", 32'({cursorX, cursorY}), 32'({7'd0, 6'd3}));
        send_byte(8'h08);
        @(negedge vgaClock);
        chk("t3_bs_noreq", 32'(memReq), 32'd0);
        chk("t3_bs_cursor", 32'({cursorX, cursorY}), 32'({7'd79, 6'd2}));
        chk("t3_model_x", 32'(cursorX), 32'(mx));

        // 4: form feed clears the whole plane
        do_byte(8'h0C, 5000);
        chk("t4_cursor", 32'({cursorX, cursorY}), 32'd0);
        chk("t4_mem0", 32'(mem[0]), 32'h20);
        chk("t4_mem3839", 32'(mem[3839]), 32'h20);
        chk("t4_mem3840_untouched", 32'(mem[3840]), 32'h00);
        chk("t4_drained", 32'(expq.size()), 32'd0);

        // 5: scroll from (10,47) with a patterned plane
        for (int i = 0; i < 47; i++) do_byte(8'h0A, 10);
        for (int i = 0; i < 10; i++) do_byte(8'h43, 10);
        chk("t5_start_y", 32'(cursorY), 32'd47);
        for (int a = 0; a < 3840; a++) begin
            mem[a] = 8'(a);
            scr[a] = 8'(a);
        end
        do_byte(8'h0A, 15000);
        bad = 0;
        for (int a = 0; a < 3840; a++) if (mem[a] !== scr[a]) bad++;
        chk("t5_ram_vs_model", 32'(bad), 32'd0);
        chk("t5_mem0", 32'(mem[0]), 32'h50);
        chk("t5_mem3759", 32'(mem[3759]), 32'hFF);
        chk("t5_mem3760", 32'(mem[3760]), 32'h20);
        chk("t5_mem3839", 32'(mem[3839]), 32'h20);
        chk("t5_cursor", 32'({cursorX, cursorY}), 32'({7'd10, 6'd47}));
        chk("t5_drained", 32'(expq.size()), 32'd0);

        // 6: reset in the middle of a clear
        send_byte(8'h0C);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge vgaClock);
            if (memReq && memAddr == 14'd100) found = 1'b1;
        end
        chk("t6_reached_addr100", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge vgaClock);
        chk("t6_req_dropped", 32'(memReq), 32'd0);
        chk("t6_cursor", 32'({cursorX, cursorY}), 32'd0);
        chk("t6_ready_in_reset", 32'(charReady), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        expq.delete();
        mx = 0;
        my = 0;
        @(posedge vgaClock);
        #1;
        reset = 1'b0;
        @(negedge vgaClock);
        chk("t6_ready_after_release", 32'(charReady), 32'd1);
        send_byte(8'h07);
        repeat (3) begin
            @(negedge vgaClock);
            chk("t6_drop_noreq", 32'(memReq), 32'd0);
        end
        chk("t6_drop_cursor", 32'({cursorX, cursorY}), 32'd0);
        chk("t6_drop_ready", 32'(charReady), 32'd1);
        chk("t6_drained", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
